// File: rtl/path_mailbox_pkg.sv
// Shared definitions for the path mailbox: register offsets, FSM states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package path_mailbox_pkg;

    // Default node index width; the top-level NODE_W parameter falls back to this.
    localparam int DEF_NODE_W = 5;

    // Byte offsets inside the 256-byte register window.
    localparam logic [7:0] OFS_START  = 8'h00;
    localparam logic [7:0] OFS_END    = 8'h04;
    localparam logic [7:0] OFS_PATH   = 8'h08;
    localparam logic [7:0] OFS_DONE   = 8'h0C;
    localparam logic [7:0] OFS_STATUS = 8'h10;
    localparam logic [7:0] OFS_LEN    = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } mbx_state_t;

    // Returns {in_window, offset[7:0]}. The subtraction wraps, so addresses
    // below the base land far outside the window and are rejected too.
    function automatic logic [8:0] win_decode(input logic [31:0] addr,
                                              input logic [31:0] base);
        logic [31:0] ofs;
        ofs = addr - base;
        return {(ofs[31:8] == 24'd0), ofs[7:0]};
    endfunction

endpackage

// File: rtl/path_fifo.sv
// Circular node FIFO with flush; pointers wrap modulo DEPTH so any depth works.
// Latency: a pushed node is visible on dout the cycle after the push.
// Backpressure: push while full is dropped, pop while empty is ignored; flush has priority.
//
// Ports: clk, reset_n (async active-low), push/din, pop, flush,
//        dout (head entry), full, empty, count (0..DEPTH).
module path_fifo #(
    parameter int DEPTH = 12,
    parameter int W     = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap instead of natural overflow: DEPTH need not be a power of 2.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/path_mailbox.sv
// Memory-mapped pathfinding mailbox: host loads START/END, CPU returns a path that is streamed out.
// Latency: CPU read data one cycle after address; first path node the cycle after DONE=1.
// Backpressure: path_valid holds a node until path_ready; pushes into a full FIFO are dropped (overflow).
//
// Ports:
//   clk, reset_n                           clock, async active-low reset
//   ext_mem_wrt/ext_data_addr/ext_wrt_data host write port (START, END)
//   cpu_mem_write/cpu_addr/cpu_wr_data     CPU write port (PATH, DONE, STATUS clear, LEN)
//   cpu_rd_data                            registered CPU read data (START, END, STATUS)
//   path_node/path_valid/path_ready        node stream to the path follower
//   path_len, busy, overflow, len_err      status outputs
// STATUS reads as {overflow, len_err, done, count} packed from bit 0 upward
// (count occupies the low $clog2(PATH_DEPTH+1) bits); a write with bit31 set
// clears overflow and len_err.
// Optional feature macro: PATH_LEN_CHECK_EN -- when defined, a LEN/count
// mismatch at DONE flushes the path, sets len_err and returns to IDLE.
module path_mailbox
    import path_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          PATH_DEPTH = 12,
    parameter int          NODE_W     = DEF_NODE_W,
    parameter int          LEN_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ext_mem_wrt,
    input  logic [31:0]       ext_data_addr,
    input  logic [31:0]       ext_wrt_data,
    input  logic              cpu_mem_write,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic [31:0]       cpu_rd_data,
    output logic [NODE_W-1:0] path_node,
    output logic              path_valid,
    input  logic              path_ready,
    output logic [LEN_W-1:0]  path_len,
    output logic              busy,
    output logic              overflow,
    output logic              len_err
);
    localparam int CNT_W = $clog2(PATH_DEPTH + 1);

    mbx_state_t        state;
    mbx_state_t        state_nx;
    logic [NODE_W-1:0] start_reg;
    logic [NODE_W-1:0] end_reg;
    logic              start_seen;
    logic              end_seen;
    logic              done_reg;
    logic [31:0]       rd_nx;

    logic              ext_in;
    logic [7:0]        ext_ofs;
    logic              cpu_in;
    logic [7:0]        cpu_ofs;

    logic              host_start;
    logic              host_end;
    logic              host_hit;
    logic              cpu_wr_hit;
    logic              cpu_path_wr;
    logic              cpu_done_wr;
    logic              cpu_len_wr;
    logic              cpu_clr;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              clr_done;
    logic [NODE_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Only low node bits, bit0 and bit31 of the data buses carry meaning.
    logic              unused_bits;
    assign unused_bits = ^{ext_wrt_data, cpu_wr_data};

    assign {ext_in, ext_ofs} = win_decode(ext_data_addr, BASE_ADDR);
    assign {cpu_in, cpu_ofs} = win_decode(cpu_addr, BASE_ADDR);

    assign host_start = ext_mem_wrt && ext_in && (ext_ofs == OFS_START);
    assign host_end   = ext_mem_wrt && ext_in && (ext_ofs == OFS_END);
    assign host_hit   = host_start || host_end;

    // A host write owns the cycle: CPU PATH/DONE writes colliding with it are
    // dropped, while LEN and the STATUS clear still land.
    assign cpu_wr_hit  = cpu_mem_write && cpu_in;
    assign cpu_path_wr = cpu_wr_hit && (cpu_ofs == OFS_PATH) && !host_hit;
    assign cpu_done_wr = cpu_wr_hit && (cpu_ofs == OFS_DONE) && !host_hit;
    assign cpu_len_wr  = cpu_wr_hit && (cpu_ofs == OFS_LEN);
    assign cpu_clr     = cpu_wr_hit && (cpu_ofs == OFS_STATUS) && cpu_wr_data[31];

    assign fifo_push  = (state == COMPUTE) && cpu_path_wr;
    assign path_valid = (state == DRAIN) && !fifo_empty;
    assign fifo_pop   = path_valid && path_ready;
    // Gate the head so stale FIFO contents never show on the output.
    assign path_node  = path_valid ? fifo_dout : '0;
    assign busy       = (state != IDLE);

`ifdef PATH_LEN_CHECK_EN
    logic len_bad;
    logic len_err_set;
    assign len_bad = (32'(path_len) != 32'(fifo_count));
`endif

    always_comb begin
        state_nx   = state;
        fifo_flush = 1'b0;
        clr_done   = 1'b0;
`ifdef PATH_LEN_CHECK_EN
        len_err_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (host_hit) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // Both endpoints must have been written during this LOAD round.
                if (host_hit && (start_seen || host_start) && (end_seen || host_end)) begin
                    state_nx   = COMPUTE;
                    fifo_flush = 1'b1;
                    clr_done   = 1'b1;
                end
            end
            COMPUTE: begin
                if (host_hit) begin
                    state_nx   = LOAD;
                    fifo_flush = 1'b1;
                    clr_done   = 1'b1;
                end else if (cpu_done_wr && cpu_wr_data[0]) begin
                    if (fifo_empty) begin
                        state_nx = IDLE;
                    end
`ifdef PATH_LEN_CHECK_EN
                    else if (len_bad) begin
                        state_nx    = IDLE;
                        fifo_flush  = 1'b1;
                        len_err_set = 1'b1;
                    end
`endif
                    else begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (host_hit) begin
                    state_nx   = LOAD;
                    fifo_flush = 1'b1;
                    clr_done   = 1'b1;
                end else if (fifo_empty || (fifo_pop && (fifo_count == CNT_W'(1)))) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_nx = '0;
        if (cpu_in) begin
            case (cpu_ofs)
                OFS_START:  rd_nx = 32'(start_reg);
                OFS_END:    rd_nx = 32'(end_reg);
                OFS_STATUS: rd_nx = 32'({overflow, len_err, done_reg, fifo_count});
                default:    rd_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_reg   <= '0;
            end_reg     <= '0;
            start_seen  <= 1'b0;
            end_seen    <= 1'b0;
            done_reg    <= 1'b0;
            path_len    <= '0;
            overflow    <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            state <= state_nx;
            if (host_start) begin
                start_reg <= ext_wrt_data[NODE_W-1:0];
            end
            if (host_end) begin
                end_reg <= ext_wrt_data[NODE_W-1:0];
            end
            // Seen flags accumulate only while in LOAD; any other state restarts
            // them from the write that (re)enters LOAD.
            start_seen <= (state == LOAD) ? (start_seen || host_start) : host_start;
            end_seen   <= (state == LOAD) ? (end_seen || host_end) : host_end;
            if (clr_done) begin
                done_reg <= 1'b0;
            end else if (cpu_done_wr) begin
                done_reg <= cpu_wr_data[0];
            end
            if (cpu_len_wr) begin
                path_len <= cpu_wr_data[LEN_W-1:0];
            end
            if (cpu_clr) begin
                overflow <= 1'b0;
            end else if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end
            cpu_rd_data <= rd_nx;
        end
    end

`ifdef PATH_LEN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_err <= 1'b0;
        end else if (cpu_clr) begin
            len_err <= 1'b0;
        end else if (len_err_set) begin
            len_err <= 1'b1;
        end
    end
`else
    assign len_err = 1'b0;
`endif

    path_fifo #(
        .DEPTH (PATH_DEPTH),
        .W     (NODE_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (cpu_wr_data[NODE_W-1:0]),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_path_mailbox.sv
// Scoreboard bench for path_mailbox: expected read data and path nodes are queued by the stimulus
// and checked by a monitor when a read response is due or a node handshake occurs.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_path_mailbox;
    import path_mailbox_pkg::*;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_mem_wrt = 1'b0;
    logic [31:0] ext_data_addr = '0;
    logic [31:0] ext_wrt_data = '0;
    logic        cpu_mem_write = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic [31:0] cpu_rd_data;
    logic [4:0]  path_node;
    logic        path_valid;
    logic        path_ready = 1'b0;
    logic [3:0]  path_len;
    logic        busy;
    logic        overflow;
    logic        len_err;

    always #5 clk = ~clk;

    path_mailbox #(
        .BASE_ADDR  (BASE),
        .PATH_DEPTH (12),
        .NODE_W     (5),
        .LEN_W      (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ext_mem_wrt   (ext_mem_wrt),
        .ext_data_addr (ext_data_addr),
        .ext_wrt_data  (ext_wrt_data),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_rd_data   (cpu_rd_data),
        .path_node     (path_node),
        .path_valid    (path_valid),
        .path_ready    (path_ready),
        .path_len      (path_len),
        .busy          (busy),
        .overflow      (overflow),
        .len_err       (len_err)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd[$];
    logic [4:0]  exp_node[$];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: read responses are due one cycle after a read was issued;
    // nodes are checked on every valid/ready handshake.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cpu_rd: got 0x%0h, expected no pending read", cpu_rd_data);
            end else begin
                chk("cpu_rd", cpu_rd_data, exp_rd.pop_front());
            end
        end
        rd_pend = rd_req;
        if (path_valid && path_ready) begin
            if (exp_node.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL path_node: got %0d, expected no node", path_node);
            end else begin
                chk("path_node", 32'(path_node), 32'(exp_node.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [31:0] addr, input logic [31:0] d);
        ext_mem_wrt   = 1'b1;
        ext_data_addr = addr;
        ext_wrt_data  = d;
        tick();
        ext_mem_wrt   = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] ofs, input logic [31:0] d);
        cpu_mem_write = 1'b1;
        cpu_addr      = BASE + 32'(ofs);
        cpu_wr_data   = d;
        tick();
        cpu_mem_write = 1'b0;
    endtask

    task automatic both_wr(input logic [7:0] hofs, input logic [31:0] hd,
                           input logic [7:0] cofs, input logic [31:0] cd);
        ext_mem_wrt   = 1'b1;
        ext_data_addr = BASE + 32'(hofs);
        ext_wrt_data  = hd;
        cpu_mem_write = 1'b1;
        cpu_addr      = BASE + 32'(cofs);
        cpu_wr_data   = cd;
        tick();
        ext_mem_wrt   = 1'b0;
        cpu_mem_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [31:0] addr, input logic [31:0] e);
        cpu_addr = addr;
        rd_req   = 1'b1;
        exp_rd.push_back(e);
        tick();
        rd_req   = 1'b0;
    endtask

    task automatic push_node(input logic [4:0] n, input bit emitted);
        if (emitted) exp_node.push_back(n);
        cpu_wr(OFS_PATH, 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic load_run(input logic [4:0] s, input logic [4:0] e);
        host_wr(BASE + 32'(OFS_START), 32'(s));
        host_wr(BASE + 32'(OFS_END), 32'(e));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #3;
        chk("rst_rd_data", cpu_rd_data, 32'd0);
        chk("rst_path_valid", 32'(path_valid), 32'd0);
        chk("rst_path_node", 32'(path_node), 32'd0);
        chk("rst_path_len", 32'(path_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        #9 reset_n = 1'b1;
        tick();

        // Out-of-window host writes are ignored
        host_wr(32'h0200_0100, 32'd9);
        host_wr(32'h01FF_FFFC, 32'd9);
        chk("oow_busy", 32'(busy), 32'd0);
        cpu_rd(BASE + 32'(OFS_START), 32'd0);

        // START=3 / END=17 handshake, CPU readback
        host_wr(BASE + 32'(OFS_START), 32'd3);
        chk("load_busy", 32'(busy), 32'd1);
        host_wr(BASE + 32'(OFS_END), 32'd17);
        chk("compute_busy", 32'(busy), 32'd1);
        cpu_rd(BASE + 32'(OFS_START), 32'd3);
        cpu_rd(BASE + 32'(OFS_END), 32'd17);
        cpu_rd(32'h0300_0000, 32'd0);
        cpu_rd(BASE + 32'h14, 32'd0);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h0);

        // Normal path 3,8,12,17
        path_ready = 1'b1;
        push_node(5'd3, 1'b1);
        push_node(5'd8, 1'b1);
        push_node(5'd12, 1'b1);
        push_node(5'd17, 1'b1);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h4);
        cpu_wr(OFS_LEN, 32'd4);
        chk("path_len4", 32'(path_len), 32'd4);
        cpu_wr(OFS_DONE, 32'd1);
        chk("drain_valid", 32'(path_valid), 32'd1);
        wait_idle("drain_idle");
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h10);

        // Overflow: 13 pushes into a 12-deep FIFO
        load_run(5'd1, 5'd2);
        for (int i = 0; i < 13; i++) begin
            push_node(5'(i + 1), i < 12);
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h4C);
        cpu_wr(OFS_LEN, 32'd12);
        cpu_wr(OFS_DONE, 32'd1);
        wait_idle("ovf_idle");
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h50);
        cpu_wr(OFS_STATUS, 32'h8000_0000);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Abort during DRAIN with path_ready low
        path_ready = 1'b0;
        load_run(5'd4, 5'd6);
        push_node(5'd7, 1'b0);
        push_node(5'd9, 1'b0);
        cpu_wr(OFS_LEN, 32'd2);
        cpu_wr(OFS_DONE, 32'd1);
        chk("hold_valid", 32'(path_valid), 32'd1);
        chk("hold_node", 32'(path_node), 32'd7);
        host_wr(BASE + 32'(OFS_START), 32'd5);
        chk("abort_valid", 32'(path_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h0);
        cpu_rd(BASE + 32'(OFS_START), 32'd5);
        host_wr(BASE + 32'(OFS_END), 32'd10);
        cpu_wr(OFS_DONE, 32'd1);
        chk("empty_done_idle", 32'(busy), 32'd0);
        path_ready = 1'b1;

        // Length check: 3 nodes, LEN=5
        load_run(5'd0, 5'd1);
`ifdef PATH_LEN_CHECK_EN
        push_node(5'd21, 1'b0);
        push_node(5'd22, 1'b0);
        push_node(5'd23, 1'b0);
`else
        push_node(5'd21, 1'b1);
        push_node(5'd22, 1'b1);
        push_node(5'd23, 1'b1);
`endif
        cpu_wr(OFS_LEN, 32'd5);
        cpu_wr(OFS_DONE, 32'd1);
        wait_idle("len_idle");
`ifdef PATH_LEN_CHECK_EN
        chk("len_err_set", 32'(len_err), 32'd1);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h30);
`else
        chk("len_err_tied", 32'(len_err), 32'd0);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h10);
`endif
        cpu_wr(OFS_STATUS, 32'h8000_0000);
        chk("len_err_clear", 32'(len_err), 32'd0);

        // Host/CPU collisions and CPU PATH writes outside COMPUTE
        cpu_wr(OFS_PATH, 32'd31);
        host_wr(BASE + 32'(OFS_START), 32'd7);
        cpu_wr(OFS_PATH, 32'd30);
        both_wr(OFS_END, 32'd8, OFS_LEN, 32'd9);
        chk("len_with_host", 32'(path_len), 32'd9);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h0);
        push_node(5'd11, 1'b0);
        push_node(5'd12, 1'b0);
        both_wr(OFS_START, 32'd13, OFS_DONE, 32'd1);
        chk("collide_valid", 32'(path_valid), 32'd0);
        chk("collide_busy", 32'(busy), 32'd1);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h0);
        host_wr(BASE + 32'(OFS_END), 32'd14);
        cpu_wr(OFS_DONE, 32'd1);
        chk("collide_idle", 32'(busy), 32'd0);
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h10);

        // Asynchronous reset mid-COMPUTE with 2 nodes queued
        load_run(5'd6, 5'd9);
        push_node(5'd1, 1'b0);
        push_node(5'd2, 1'b0);
        cpu_wr(OFS_LEN, 32'd2);
        cpu_rd(BASE + 32'(OFS_START), 32'd6);
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_rd_data", cpu_rd_data, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_path_len", 32'(path_len), 32'd0);
        chk("arst_valid", 32'(path_valid), 32'd0);
        chk("arst_node", 32'(path_node), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        cpu_rd(BASE + 32'(OFS_STATUS), 32'h0);
        tick();
        tick();

        chk("nodes_left", 32'(exp_node.size()), 32'd0);
        chk("reads_left", 32'(exp_rd.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
